// File: rtl/pc_stack.sv
// Program counter with conditional jump, call/return through a small LIFO
// return-address stack, and sticky stack-error reporting.
module pc_stack #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int SPW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ce,
   input  logic             j_n,
   input  logic             cond_en,
   input  logic             flag,
   input  logic             call,
   input  logic             ret,
   input  logic             co,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   output logic [WIDTH-1:0] pc_q,
   output logic [SPW-1:0]   sp,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             err
);

   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

   // Sized to the full pointer range so sp indexes it directly; slots at and
   // above DEPTH are never written.
   logic [WIDTH-1:0] stack_mem [2**SPW];
   logic [WIDTH-1:0] pc_inc;
   logic             pop;
   logic             push;
   logic             jump;
   logic             stk_err;

   assign bus_oe    = co;
   assign bus_out   = co ? pc_q : '0;
   assign stk_full  = (sp == SP_FULL);
   assign stk_empty = (sp == '0);
   assign pc_inc    = pc_q + WIDTH'(1);

   // Requests are level-sampled on every rising edge; exactly one action is
   // taken per cycle, ret over call over jump over count.
   always_comb begin
      pop     = 1'b0;
      push    = 1'b0;
      jump    = 1'b0;
      stk_err = 1'b0;
      if (ret) begin
         if (stk_empty) stk_err = 1'b1;
         else           pop     = 1'b1;
      end else if (call) begin
         if (stk_full) stk_err = 1'b1;
         else          push    = 1'b1;
      end else if (!j_n && (!cond_en || flag)) begin
         jump = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pc_q <= '0;
         sp   <= '0;
         err  <= 1'b0;
      end else begin
         if (stk_err) err <= 1'b1;
         if (pop) begin
            pc_q <= stack_mem[sp - SP_ONE];
            sp   <= sp - SP_ONE;
         end else if (push) begin
            pc_q <= bus_in;
            sp   <= sp + SP_ONE;
         end else if (jump) begin
            pc_q <= bus_in;
         end else if (ce && !ret && !call) begin
            pc_q <= pc_inc;
         end
      end
   end

   // Stack storage is not reset; a held clr suppresses the push.
   always_ff @(posedge clk) begin
      if (push && !clr) stack_mem[sp] <= pc_inc;
   end

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: a 4-bit/4-deep and an 8-bit/2-deep instance share
// control inputs and are checked against a behavioural stack model.
module tb_pc_stack;

   localparam int EW = 44;

   logic       clk = 1'b0;
   logic       clr, ce, j_n, cond_en, flag, call, ret, co;
   logic [7:0] bin;

   logic [3:0] bo4, pc4;
   logic       oe4, full4, empty4, err4;
   logic [2:0] sp4;
   logic [7:0] bo8, pc8;
   logic       oe8, full8, empty8, err8;
   logic [1:0] sp8;

   int n_checks = 0;
   int n_fail   = 0;

   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];

   int m_pc[2], m_sp[2], m_err[2];
   int m_stk[2][16];
   int mw[2] = '{4, 8};
   int md[2] = '{4, 2};

   pc_stack #(.WIDTH(4), .DEPTH(4)) u_dut4 (
      .clk(clk), .clr(clr), .ce(ce), .j_n(j_n), .cond_en(cond_en), .flag(flag),
      .call(call), .ret(ret), .co(co), .bus_in(bin[3:0]),
      .bus_out(bo4), .bus_oe(oe4), .pc_q(pc4), .sp(sp4),
      .stk_full(full4), .stk_empty(empty4), .err(err4)
   );

   pc_stack #(.WIDTH(8), .DEPTH(2)) u_dut8 (
      .clk(clk), .clr(clr), .ce(ce), .j_n(j_n), .cond_en(cond_en), .flag(flag),
      .call(call), .ret(ret), .co(co), .bus_in(bin),
      .bus_out(bo8), .bus_oe(oe8), .pc_q(pc8), .sp(sp8),
      .stk_full(full8), .stk_empty(empty8), .err(err8)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [EW-1:0] pack(logic [15:0] pc, logic [15:0] bo, logic oe,
                                          logic [7:0] s, logic full, logic empty, logic e);
      return {pc, bo, oe, s, full, empty, e};
   endfunction

   function automatic string fmt(logic [EW-1:0] w);
      return $sformatf("pc=%0h bus=%0h oe=%0b sp=%0d full=%0b empty=%0b err=%0b",
                       w[43:28], w[27:12], w[11], w[10:3], w[2], w[1], w[0]);
   endfunction

   function automatic logic [EW-1:0] act_word(int d);
      if (d == 0) return pack(16'(pc4), 16'(bo4), oe4, 8'(sp4), full4, empty4, err4);
      return pack(16'(pc8), 16'(bo8), oe8, 8'(sp8), full8, empty8, err8);
   endfunction

   function automatic logic [EW-1:0] exp_word(int d);
      return pack(16'(m_pc[d]), 16'(co ? m_pc[d] : 0), co, 8'(m_sp[d]),
                  m_sp[d] == md[d], m_sp[d] == 0, m_err[d] != 0);
   endfunction

   task automatic check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
      end
   endtask

   // reference model: one cycle of the stack machine for instance d
   task automatic model_step(int d);
      int mask;
      mask = (1 << mw[d]) - 1;
      if (clr) begin
         m_pc[d] = 0; m_sp[d] = 0; m_err[d] = 0;
      end else if (ret) begin
         if (m_sp[d] == 0) m_err[d] = 1;
         else begin
            m_sp[d] = m_sp[d] - 1;
            m_pc[d] = m_stk[d][m_sp[d]];
         end
      end else if (call) begin
         if (m_sp[d] == md[d]) m_err[d] = 1;
         else begin
            m_stk[d][m_sp[d]] = (m_pc[d] + 1) & mask;
            m_sp[d] = m_sp[d] + 1;
            m_pc[d] = int'(bin) & mask;
         end
      end else if (!j_n && (!cond_en || flag)) begin
         m_pc[d] = int'(bin) & mask;
      end else if (ce) begin
         m_pc[d] = (m_pc[d] + 1) & mask;
      end
   endtask

   // driver tasks
   task automatic begin_cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic end_cyc();
      for (int d = 0; d < 2; d++) model_step(d);
      exp_q0.push_back(exp_word(0));
      exp_q1.push_back(exp_word(1));
      @(posedge clk);
   endtask

   task automatic cyc(logic ce_v, logic jn_v, logic cond_v, logic flag_v, logic call_v,
                      logic ret_v, logic co_v, logic clr_v, logic [7:0] bin_v);
      begin_cyc();
      ce = ce_v; j_n = jn_v; cond_en = cond_v; flag = flag_v;
      call = call_v; ret = ret_v; co = co_v; clr = clr_v; bin = bin_v;
      end_cyc();
   endtask

   task automatic count(int n, logic co_v);
      for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, co_v, 0, 8'h00);
   endtask

   task automatic do_clr();
      cyc(0, 1, 0, 0, 0, 0, 1, 1, 8'h00);
   endtask

   // scoreboard monitor: one expected entry per clocked cycle, per instance
   always @(negedge clk) begin
      if (exp_q0.size() > 0) check("dut4", act_word(0), exp_q0.pop_front());
      if (exp_q1.size() > 0) check("dut8", act_word(1), exp_q1.pop_front());
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_pc[d] = 0; m_sp[d] = 0; m_err[d] = 0;
      end
      clr = 1'b0; ce = 1'b0; j_n = 1'b1; cond_en = 1'b0; flag = 1'b0;
      call = 1'b0; ret = 1'b0; co = 1'b0; bin = 8'h00;
      #2 clr = 1'b1;
      #1;
      check("reset4", act_word(0), exp_word(0));
      check("reset8", act_word(1), exp_word(1));
      do_clr();

      // count with wrap, bus gated by co
      count(17, 0);
      count(3, 1);

      // jumps from pc=3
      do_clr();
      count(3, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 8'h0A);
      cyc(1, 0, 1, 0, 0, 0, 1, 0, 8'h02);
      cyc(1, 0, 1, 1, 0, 0, 1, 0, 8'h02);

      // nested call/return from pc=1
      do_clr();
      count(1, 1);
      cyc(0, 1, 0, 0, 1, 0, 1, 0, 8'h08);
      cyc(0, 1, 0, 0, 1, 0, 1, 0, 8'h0C);
      cyc(0, 1, 0, 0, 0, 1, 1, 0, 8'h00);
      cyc(0, 1, 0, 0, 0, 1, 1, 0, 8'h00);

      // overflow, then underflow with sticky err
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 0, 1, 0, 8'(i * 3 + 1));
      do_clr();
      cyc(0, 1, 0, 0, 0, 1, 1, 0, 8'h00);
      count(4, 1);

      // call+ret together, call over jump
      do_clr();
      count(4, 1);
      cyc(0, 1, 0, 0, 1, 0, 1, 0, 8'h09);
      cyc(1, 0, 0, 0, 1, 1, 1, 0, 8'h03);
      cyc(1, 0, 0, 0, 1, 0, 1, 0, 8'h0E);
      cyc(0, 1, 0, 0, 0, 1, 1, 0, 8'h00);

      // asynchronous clr mid-call
      count(2, 1);
      cyc(0, 1, 0, 0, 1, 0, 1, 0, 8'h06);
      begin_cyc();
      ce = 1'b1; call = 1'b1; ret = 1'b0; j_n = 1'b1; co = 1'b1; bin = 8'h07;
      #2 clr = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         m_pc[d] = 0; m_sp[d] = 0; m_err[d] = 0;
      end
      check("async_clr4", act_word(0), exp_word(0));
      check("async_clr8", act_word(1), exp_word(1));
      end_cyc();
      cyc(0, 1, 0, 0, 0, 1, 1, 0, 8'h00);

      // 8-bit wrap 0xFF -> 0x00
      do_clr();
      count(260, 1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0, 8'($urandom_range(0, 255)));
      end

      begin_cyc();
      n_checks++;
      if (exp_q0.size() + exp_q1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q0.size() + exp_q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the 8-bit CPU, generalising the 4-bit PC to WIDTH bits.
- Adds conditional jump, subroutine call/return through an internal LIFO return-address stack of DEPTH entries, and sticky stack-error reporting.
- Sits between the control sequencer and the shared address bus.
- Drives its bus-output channel only when output is enabled. The top level performs the tri-state merge.

Parameters:
WIDTH, 4, PC and bus width in bits (legal 2..16).
DEPTH, 4, return-stack entries (legal 1..16).
SPW, $clog2(DEPTH+1), stack-pointer width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-high reset
ce  input  1  count enable, active high
j_n  input  1  jump/load request, active low
cond_en  input  1  1 = jump is conditional on flag
flag  input  1  ALU condition flag (zero/carry, selected upstream)
call  input  1  call request, active high
ret  input  1  return request, active high
co  input  1  counter-out enable, active high
bus_in  input  WIDTH  address sampled from bus
bus_out  output  WIDTH  PC value for bus; 0 when co=0
bus_oe  output  1  equals co; tri-state enable for top level
pc_q  output  WIDTH  current PC (debug/monitor)
sp  output  SPW  number of occupied stack entries
stk_full  output  1  sp == DEPTH
stk_empty  output  1  sp == 0
err  output  1  sticky stack overflow/underflow flag

Behaviour:
- clr=1, asynchronous: pc_q=0, sp=0, err=0. stk_empty=1 and stk_full=0 follow from sp. Stack RAM contents are undefined and not cleared.
- clr asserted mid-operation aborts any request in that cycle. First action is on the first rising edge after clr deasserts.
- bus_out = co ? pc_q : 0. bus_oe = co. Both are combinational with zero latency and independent of every other control.
- All PC updates happen on the rising clk edge. Priority, highest first, one action per cycle:
  1. ret=1: if sp>0, pc_q <= stack[sp-1] and sp <= sp-1. If sp==0 (underflow), pc_q holds, sp holds, err <= 1.
  2. call=1: if sp<DEPTH, stack[sp] <= pc_q+1 (mod 2^WIDTH), sp <= sp+1, pc_q <= bus_in. If sp==DEPTH (overflow), pc_q holds, sp holds, stack is unchanged, err <= 1.
  3. j_n=0 and (cond_en=0 or flag=1): pc_q <= bus_in (jump taken).
  4. j_n=0, cond_en=1, flag=0: jump not taken. Behaves as the row below, i.e. increments if ce=1.
  5. ce=1: pc_q <= pc_q+1. Wraps 2^WIDTH-1 -> 0 with no flag.
  6. Otherwise pc_q holds.
- call and ret are not gated by ce, and neither is a taken jump. Loads are synchronous regardless of count enable.
- call and ret asserted together: ret wins and call is ignored with no error.
- A pushed return address of 2^WIDTH-1 +1 wraps to 0.
- err is sticky and is cleared only by clr.
- stk_full and stk_empty are combinational decodes of the registered sp.
- DEPTH=1: sp is 1 bit. Full and empty are mutually exclusive.
- There is no combinational path from bus_in to bus_out. A jump target appears on pc_q/bus_out one cycle after the edge.

Test Plan:
- Reset/count, WIDTH=4: pulse clr, then ce=1 for 17 cycles -> pc_q 0,1,...,15,0,1. With co=0, bus_out=0 throughout and bus_oe=0. With co=1, bus_out=pc_q.
- Jumps: pc_q=3, j_n=0, cond_en=0, bus_in=0xA -> pc_q=0xA. Then cond_en=1, flag=0, ce=1, bus_in=0x2 -> pc_q=0xB. Then flag=1 -> pc_q=0x2.
- Call/return nest, DEPTH=4: from pc=1, call to 0x8 -> sp=1, pc=8. Call to 0xC -> sp=2. ret -> pc=9, sp=1. ret -> pc=2, sp=0, stk_empty=1, err=0.
- Overflow/underflow: perform 4 calls to fill (stk_full=1). A 5th call -> pc and sp unchanged, err=1. clr, then ret with sp=0 -> pc stays 0, err=1, and err persists across later ce counting.
- Priority/simultaneity: call=1, ret=1 with sp=1 holding 0x5 -> pc=5, sp=0, err=0. call=1 with j_n=0 -> the call semantics apply (push occurs).
- Async reset mid-call: assert clr between edges while call=1 -> pc_q=0 and sp=0 immediately, with no push on the following edge while clr is held. Repeat with WIDTH=8, DEPTH=2 and check the wrap 0xFF -> 0x00.
